// File: rtl/pwm_sine_gen_if.sv
// Signal bundle for pwm_sine_gen: run/sync controls and frequency/phase words in,
// per-channel PWM waveforms, period strobe and active duty values out.
interface pwm_sine_gen_if #(
    parameter int CH         = 4,
    parameter int PWM_BITS   = 8,
    parameter int LUT_LOG2   = 6,
    parameter int PHASE_BITS = 16
);
    localparam int IDX = LUT_LOG2 + 2;

    logic                     enable;
    logic                     sync;
    logic [PHASE_BITS-1:0]    phase_step;
    logic [CH*IDX-1:0]        ch_offset;
    logic [CH-1:0]            pwm_out;
    logic                     period_tick;
    logic [CH*PWM_BITS-1:0]   duty;

    modport master (
        output enable, sync, phase_step, ch_offset,
        input  pwm_out, period_tick, duty
    );

    modport slave (
        input  enable, sync, phase_step, ch_offset,
        output pwm_out, period_tick, duty
    );
endinterface

// File: rtl/pwm_sine_gen.sv
// Multi-channel sine-modulated PWM: a shared phase accumulator indexes a quarter-wave
// LUT per channel; duties swap in only at period boundaries so every period is glitch-free.
module pwm_sine_gen #(
    parameter int CH         = 4,
    parameter int PWM_BITS   = 8,
    parameter int LUT_LOG2   = 6,
    parameter int PHASE_BITS = 16
) (
    input logic           clk,
    input logic           rst_n,
    pwm_sine_gen_if.slave bus
);
    localparam int IDX = LUT_LOG2 + 2;
    localparam int N   = 1 << LUT_LOG2;
    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;
    localparam logic [PWM_BITS-1:0] MID     = {1'b1, {(PWM_BITS-1){1'b0}}};

    // Elaboration-time sine via a Taylor series on [0, pi/2]; only constants reach hardware.
    function automatic logic [PWM_BITS-1:0] lut_entry(input int i);
        real x, term, s, amp;
        x    = 3.14159265358979323846 * (real'(i) + 0.5) / real'(2 * N);
        term = x;
        s    = x;
        for (int k = 1; k < 10; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            s    = s + term;
        end
        amp = real'((1 << (PWM_BITS - 1)) - 1) * s;
        return PWM_BITS'($rtoi(amp + 0.5));
    endfunction

    logic [PWM_BITS-1:0]   lut [N];

    logic [PWM_BITS-1:0]   cnt_q, cnt_d;
    logic [PHASE_BITS-1:0] acc_q, acc_d;
    logic [PHASE_BITS-1:0] step_q;
    logic [PWM_BITS-1:0]   duty_q  [CH];
    logic [PWM_BITS-1:0]   duty_d  [CH];
    logic [PWM_BITS-1:0]   nduty_q [CH];
    logic [PWM_BITS-1:0]   nduty_d [CH];
    logic [CH-1:0]         pwm_q, pwm_d;
    logic                  tick_q, tick_d;
    logic                  en_q;
    logic                  run;
    logic                  boundary;

    for (genvar gi = 0; gi < N; gi++) begin : g_lut
        localparam logic [PWM_BITS-1:0] ENTRY = lut_entry(gi);
        assign lut[gi] = ENTRY;
    end

    // Quadrant bit 0 mirrors the LUT address, bit 1 flips the sign around mid-scale.
    for (genvar gc = 0; gc < CH; gc++) begin : g_ch
        logic [IDX-1:0]      idx;
        logic [LUT_LOG2-1:0] addr;
        logic [PWM_BITS-1:0] amp;

        assign idx  = acc_q[PHASE_BITS-1 -: IDX] + bus.ch_offset[gc*IDX +: IDX];
        assign addr = idx[IDX-2] ? ~idx[LUT_LOG2-1:0] : idx[LUT_LOG2-1:0];
        assign amp  = lut[addr];
        assign nduty_d[gc] = idx[IDX-1] ? (MID - amp) : (MID + amp);
        assign bus.duty[gc*PWM_BITS +: PWM_BITS] = duty_q[gc];
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        run      = bus.enable && en_q;
        boundary = bus.enable && tick_q && !bus.sync;
        cnt_d    = '0;
        acc_d    = acc_q;
        pwm_d    = '0;
        tick_d   = 1'b0;
        for (int c = 0; c < CH; c++) begin
            duty_d[c] = duty_q[c];
        end

        if (bus.enable && bus.sync) begin
            acc_d = '0;
            for (int c = 0; c < CH; c++) begin
                duty_d[c] = '0;
            end
        end else if (boundary) begin
            acc_d = acc_q + step_q;
            for (int c = 0; c < CH; c++) begin
                duty_d[c] = nduty_q[c];
            end
        end

        // The first enabled edge parks the counter at 0 so a resumed period starts from cnt=0.
        if (run && !bus.sync) begin
            cnt_d = cnt_q + PWM_BITS'(1);
        end
        tick_d = run && !bus.sync && (cnt_d == CNT_MAX);

        for (int c = 0; c < CH; c++) begin
            pwm_d[c] = bus.enable && (cnt_d < duty_d[c]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            step_q <= '0;
            pwm_q  <= '0;
            tick_q <= 1'b0;
            en_q   <= 1'b0;
            // NOTE: the per-channel duty arrays are plain flops, not RAM, so they take the async reset too.
            for (int c = 0; c < CH; c++) begin
                duty_q[c]  <= '0;
                nduty_q[c] <= '0;
            end
        end else begin
            // NOTE: non-blocking updates make every register sample the pre-edge values of the others.
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            step_q <= bus.phase_step;
            pwm_q  <= pwm_d;
            tick_q <= tick_d;
            en_q   <= bus.enable;
            for (int c = 0; c < CH; c++) begin
                duty_q[c]  <= duty_d[c];
                nduty_q[c] <= nduty_d[c];
            end
        end
    end

    assign bus.pwm_out     = pwm_q;
    assign bus.period_tick = tick_q;
endmodule
